// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the fifo push arbiter
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  function automatic int src_id_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer handshakes plus fifo push side of the arbiter
interface fifo_push_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_WIDTH = 8);
  import fifo_arb_pkg::*;
  localparam int IW = src_id_width(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic fifo_full;
  logic fifo_push;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic [IW-1:0] fifo_src_id;
  logic grant_active;
  logic [IW-1:0] grant_id;
  modport master(input req_valid, req_data, fifo_full,
                 output req_ready, fifo_push, fifo_data_in, fifo_src_id, grant_active, grant_id);
  modport slave(output req_valid, req_data, fifo_full,
                input req_ready, fifo_push, fifo_data_in, fifo_src_id, grant_active, grant_id);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request after rr_ptr, searching with wrap
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = src_id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] start;
  logic [IW-1:0] off;
  logic [N-1:0]  rot;
  logic [IW:0]   sum;
  // rotate so rr_ptr+1 lands at bit 0, take the lowest set bit, rotate the index back
  always_comb begin
    start = (rr_ptr == IW'(N - 1)) ? '0 : rr_ptr + 1'b1;
    rot = N'({req, req} >> start);
    off = '0;
    for (int j = N - 1; j >= 0; j--) off = rot[j] ? IW'(j) : off;
    sum = {1'b0, start} + {1'b0, off};
    idx = IW'((sum >= (IW + 1)'(N)) ? sum - (IW + 1)'(N) : sum);
    found = |req;
  end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst-locked sharing of one fifo push port
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input logic clk,
  input logic reset,
  fifo_push_arbiter_if.master bus
);
  localparam int IW = src_id_width(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [BW-1:0] beat_cnt;
  logic [IW-1:0] pick;
  logic found;
  logic held;
  logic g_valid;
  logic xfer;
  logic last_beat;
  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req(bus.req_valid),
    .rr_ptr(rr_ptr),
    .found(found),
    .idx(pick)
  );
  // grant-side handshake and push muxing; everything is forced quiet while reset is high
  always_comb begin
    held = !reset && state == ARB_GRANT;
    g_valid = bus.req_valid[grant];
    xfer = held && g_valid && !bus.fifo_full;
    last_beat = beat_cnt == BW'(BURST_MAX - 1);
    bus.req_ready = (held && !bus.fifo_full) ? NUM_REQ'(1) << grant : '0;
    bus.fifo_push = xfer;
    bus.fifo_data_in = xfer ? bus.req_data[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
    bus.fifo_src_id = xfer ? grant : '0;
    bus.grant_active = held;
    bus.grant_id = held ? grant : '0;
  end
  // arbitration FSM: pick in IDLE, hold the grant until the burst cap or a valid drop
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      rr_ptr <= IW'(NUM_REQ - 1);
      grant <= '0;
      beat_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (found) begin
        grant <= pick;
        state <= ARB_GRANT;
      end
    end else if (!g_valid || (xfer && last_beat)) begin
      rr_ptr <= grant;
      beat_cnt <= '0;
      state <= ARB_IDLE;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_fifo_push_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  logic clk = 0;
  logic reset = 1;
  logic full = 0;
  bit rnd = 0;
  always #5 clk = ~clk;
  fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  fifo_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int left[N];
  logic [7:0] dat[N];
  logic [N-1:0] acc = '0;
  int plog_d[$];
  int plog_s[$];
  bit m_busy = 0;
  int m_g = 0;
  int m_last = N - 1;
  int m_beats = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: the owner keeps the port until BM beats or its valid drops; next owner is
  // the first valid index after the last released one, wrapping
  always @(negedge clk) begin
    logic [N-1:0] er;
    logic ep, ea;
    int eg, ed, es;
    bit got;
    er = '0; ep = 0; ea = 0; eg = 0; ed = 0; es = 0; got = 0;
    if (reset) begin
      m_busy = 0; m_last = N - 1; m_beats = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++)
        if (!got && bus.req_valid[(m_last + k) % N]) begin
          m_g = (m_last + k) % N; got = 1;
        end
      m_busy = got;
    end else begin
      ea = 1; eg = m_g;
      er[m_g] = !bus.fifo_full;
      ep = bus.req_valid[m_g] && !bus.fifo_full;
      ed = int'(bus.req_data[m_g*DW +: DW]);
      es = m_g;
      if (!bus.req_valid[m_g]) begin
        m_busy = 0; m_last = m_g; m_beats = 0;
      end else if (ep) begin
        m_beats++;
        if (m_beats == BM) begin
          m_busy = 0; m_last = m_g; m_beats = 0;
        end
      end
    end
    chk("ready", 32'(bus.req_ready), 32'(er));
    chk("push", 32'(bus.fifo_push), 32'(ep));
    chk("grant_active", 32'(bus.grant_active), 32'(ea));
    chk("grant_id", 32'(bus.grant_id), 32'(eg));
    if (ep) begin
      chk("data", 32'(bus.fifo_data_in), 32'(ed));
      chk("src_id", 32'(bus.fifo_src_id), 32'(es));
    end
    acc = bus.req_valid & bus.req_ready;
    if (bus.fifo_push) begin
      plog_d.push_back(int'(bus.fifo_data_in));
      plog_s.push_back(int'(bus.fifo_src_id));
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = left[i] > 0;
      bus.req_data[i*DW +: DW] = dat[i];
    end
    bus.fifo_full = full;
  endtask

  task automatic arm(input int i, input int n, input logic [7:0] d);
    left[i] = n; dat[i] = d;
    drive();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        left[i]--; dat[i]++;
      end
      if (rnd && left[i] == 0 && $urandom_range(3) == 0) begin
        left[i] = $urandom_range(6, 1); dat[i] = 8'($urandom);
      end
    end
    if (rnd) begin
      full = $urandom_range(4) == 0;
      reset = $urandom_range(299) == 0;
    end
    drive();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) left[i] = 0;
    full = 0; reset = 1;
    drive();
    cyc(); cyc();
    reset = 0;
    plog_d.delete(); plog_s.delete();
  endtask

  task automatic wait_pushes(input int n, input int budget);
    int c = 0;
    while (plog_s.size() < n && c < budget) begin
      cyc(); c++;
    end
    chk("push_count_reached", 32'(plog_s.size() >= n), 1);
  endtask

  task automatic wait_grant(input int id, input int budget);
    int c = 0;
    while (!(bus.grant_active && int'(bus.grant_id) == id) && c < budget) begin
      cyc(); c++;
    end
    chk("grant_reached", 32'(bus.grant_active && int'(bus.grant_id) == id), 1);
  endtask

  task automatic chk_log(input int k, input int s, input int d);
    if (plog_s.size() > k) begin
      chk("log_src", 32'(plog_s[k]), 32'(s));
      chk("log_data", 32'(plog_d[k]), 32'(d));
    end else chk("log_len", 32'(plog_s.size()), 32'(k + 1));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      left[i] = 0; dat[i] = '0;
    end
    drive();
    for (int i = 0; i < N; i++) arm(i, 1, 8'(i * 16 + 1));
    repeat (2) begin
      cyc(); #2;
      chk("rst_push", 32'(bus.fifo_push), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_active", 32'(bus.grant_active), 0);
    end
    reset = 0;
    plog_d.delete(); plog_s.delete();
    #1 chk("idle_after_reset", 32'(bus.grant_active), 0);
    cyc(); #2;
    chk("first_grant_active", 32'(bus.grant_active), 1);
    chk("first_grant_id", 32'(bus.grant_id), 0);
    wait_pushes(4, 30);
    arm(0, 1, 8'h05);
    wait_pushes(5, 30);
    chk_log(0, 0, 'h01); chk_log(1, 1, 'h11); chk_log(2, 2, 'h21);
    chk_log(3, 3, 'h31); chk_log(4, 0, 'h05);

    do_reset();
    arm(0, 8, 8'h10); arm(2, 8, 8'h20);
    wait_pushes(16, 80);
    for (int k = 0; k < 16; k++)
      chk_log(k, ((k / 4) % 2) ? 2 : 0, (((k / 4) % 2) ? 'h20 : 'h10) + (k / 8) * 4 + k % 4);

    do_reset();
    arm(1, 4, 8'h30);
    wait_pushes(2, 20);
    full = 1;
    drive();
    repeat (5) begin
      #2;
      chk("full_push", 32'(bus.fifo_push), 0);
      chk("full_ready", 32'(bus.req_ready), 0);
      chk("full_gid", 32'(bus.grant_id), 1);
      chk("full_active", 32'(bus.grant_active), 1);
      cyc();
    end
    full = 0;
    drive();
    wait_pushes(4, 20);
    cyc(); cyc(); cyc();
    chk("stall_total", 32'(plog_s.size()), 4);
    chk("stall_released", 32'(bus.grant_active), 0);
    for (int k = 0; k < 4; k++) chk_log(k, 1, 'h30 + k);

    do_reset();
    arm(3, 1, 8'h40);
    wait_grant(3, 10);
    arm(1, 1, 8'h51); arm(2, 1, 8'h52);
    wait_pushes(3, 30);
    chk_log(0, 3, 'h40); chk_log(1, 1, 'h51); chk_log(2, 2, 'h52);

    do_reset();
    arm(2, 4, 8'h60);
    wait_pushes(1, 20);
    reset = 1;
    #2;
    chk("rst_mid_push", 32'(bus.fifo_push), 0);
    chk("rst_mid_ready", 32'(bus.req_ready), 0);
    arm(1, 2, 8'h70);
    cyc();
    reset = 0;
    plog_d.delete(); plog_s.delete();
    wait_grant(1, 5);
    wait_pushes(1, 10);
    chk_log(0, 1, 'h70);

    do_reset();
    rnd = 1;
    repeat (3000) cyc();
    rnd = 0;
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
